ctrl_sequencer: RTL and testbench
=================================

# ctrl_sequencer

Sequencing control unit upstream of the datapath. It decodes the 4-bit `opcode` and `fcode` into the datapath's `CTRL_*` strobes, generates the datapath `START` (reset) pulse, and runs a req/ack program-execution handshake with the host. It also maintains a run-cycle counter with watchdog timeout and forces all control strobes inactive outside the RUN state.

## Interface
Parameters:
- `INIT_CYCLES`, default 2: number of cycles `START` is held high before RUN (legal range 1..15).
- `MAX_CYCLES`, default 16'hFFFF: RUN cycle budget before timeout (legal range 1..16'hFFFF).

Ports:
- `CLK`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req`  in  1: host level request to run the program.
- `opcode`  in  4: `instr_out[8:5]` from the datapath.
- `fcode`  in  1: `instr_out[0]` from the datapath.
- `DONE`  in  1: end-of-program flag from the datapath fetch stage.
- `START`  out  1: datapath reset/initialise.
- `CTRL_branch_rel_nz`, `CTRL_branch_rel_z`, `CTRL_branch_abs`, `CTRL_reg_write_en`, `CTRL_reg_sel`, `CTRL_lut_in`, `CTRL_mem_to_reg`, `CTRL_alu_src`, `CTRL_alu_sc_in`, `CTRL_read_mem`, `CTRL_write_mem`  out  1 each: datapath strobes.
- `CTRL_alu_op`  out  3: ALU operation.
- `ack`  out  1: program finished; results valid.
- `busy`  out  1: INIT or RUN.
- `timeout`  out  1: last run ended by the watchdog.
- `cycle_count`  out  16: RUN cycles of the current or last run.

## Operation
- States: IDLE, INIT, RUN, FIN.
- IDLE → INIT when `req`=1.
- INIT lasts exactly INIT_CYCLES cycles, then → RUN. On INIT entry: `cycle_count`←0 and `timeout`←0.
- RUN: decode is live. `cycle_count` increments every RUN cycle, including the terminating one.
- RUN → FIN when any of these holds: HALT is decoded (opcode 15, fcode 0); `DONE`=1; or `cycle_count`==MAX_CYCLES-1 at the clock edge.
- Timeout: set `timeout`=1 only if the exit is by the count alone. If HALT or `DONE` coincides with the count condition, HALT/`DONE` wins and `timeout`=0.
- FIN: `ack`=1. FIN → IDLE when `req`=0.
- Abort: `req`=0 during INIT or RUN → IDLE next cycle. `ack` is never raised; `cycle_count` and `timeout` hold.
- `START`=1 in IDLE and INIT, 0 in RUN and FIN.
- `busy`=1 in INIT and RUN only.
- All `CTRL_*` outputs are 0 outside RUN, and 0 for HALT/NOP.
- Decode in RUN (ALU ops: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHL=5, SHR=6, PASS=7). Every ALU op asserts `reg_write_en`.
  - 0 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR: matching `alu_op`.
  - 1 ADDI: ADD with `alu_src`=1.
  - 6 SHL, 7 SHR: matching `alu_op`; `alu_sc_in`=`fcode`.
  - 8 LW: `read_mem`, `mem_to_reg`, `reg_write_en`.
  - 9 SW: `write_mem`.
  - 10 BZ: `branch_rel_z`.
  - 11 BNZ: `branch_rel_nz`.
  - 12 JMP: `branch_abs`.
  - 13 JR: `branch_abs` + `lut_in`.
  - 14 CALL: `reg_sel` + `reg_write_en` + `branch_abs`.
  - 15: `fcode`=0 is HALT, `fcode`=1 is NOP.
  - `alu_op`=PASS for every non-ALU opcode.
- `cycle_count` is 16-bit unsigned and cannot wrap, because MAX_CYCLES ≤ 16'hFFFF.

## Timing
- Reset values: state=IDLE, `START`=1, `ack`=0, `busy`=0, `timeout`=0, `cycle_count`=0, all `CTRL_*`=0.
- `CTRL_*` outputs are combinational from `opcode`/`fcode` gated by RUN, giving zero-latency decode to match the single-cycle datapath. The state, counters and flags are registers.
- Registered outputs (`ack`, `timeout`, `cycle_count`) change one cycle after the triggering edge condition.
- `req`→`START` falling: INIT_CYCLES+1 cycles from `req` sampled high.
- Terminating instruction: its strobes are visible in its RUN cycle. HALT strobes are all 0.
- A `reset_n` assertion mid-run returns all outputs to reset values immediately, with no clock needed.

## Structure
- Shared package `definitions`:
  - `opcode_t` enum covering all 16 opcodes.
  - `alu_op_t` enum covering all 8 ALU ops.
  - `seq_state_t`.
  - Constants `OP_HALT_F`=0 and `OP_NOP_F`=1.
- Sub-module `ctrl_decode`: purely combinational, mapping opcode/fcode to the strobe bundle. The sequencer instantiates it and ANDs its outputs with the RUN state.

## Test plan
- **Basic run:** reset, `req`=1, opcode stream ADD, ADDI, HALT → `START` high 2 cycles; `busy`=1; `CTRL_alu_src`=1 only on ADDI; `ack`=1 one cycle after HALT; `cycle_count`=3; `timeout`=0.
- **Watchdog:** MAX_CYCLES=5, opcode held at NOP → exit after 5 RUN cycles; `timeout`=1; `cycle_count`=5.
- **Coincident exit:** HALT presented on the 5th RUN cycle with MAX_CYCLES=5 → `timeout`=0; `cycle_count`=5.
- **Abort:** `req` dropped in RUN cycle 2 → IDLE; `START`=1; `ack` never rises; `cycle_count`=2.
- **Decode sweep:** opcodes 0–15 in RUN → each strobe pattern matches the Operation list. LW asserts exactly `read_mem`, `mem_to_reg`, `reg_write_en`; CALL asserts exactly `reg_sel`, `reg_write_en`, `branch_abs`.
- **Async reset:** `reset_n` low mid-RUN, off-edge → all outputs at reset values before the next `CLK` edge; `DONE`=1 in RUN → FIN with `timeout`=0.

Source files
------------

// File: rtl/ctrl_sequencer_pkg.sv
// Shared types for the sequencing control unit: opcode/ALU encodings, FSM state
// and the decoded strobe bundle.
package definitions;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDI = 4'd1,
    OP_SUB  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_LW   = 4'd8,
    OP_SW   = 4'd9,
    OP_BZ   = 4'd10,
    OP_BNZ  = 4'd11,
    OP_JMP  = 4'd12,
    OP_JR   = 4'd13,
    OP_CALL = 4'd14,
    OP_HALT = 4'd15
  } opcode_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SHL  = 3'd5,
    ALU_SHR  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_RUN  = 2'd2,
    S_FIN  = 2'd3
  } seq_state_t;

  // fcode qualifier of opcode 15
  localparam logic OP_HALT_F = 1'b0;
  localparam logic OP_NOP_F  = 1'b1;

  typedef struct packed {
    logic    branch_rel_nz;
    logic    branch_rel_z;
    logic    branch_abs;
    logic    reg_write_en;
    logic    reg_sel;
    logic    lut_in;
    logic    mem_to_reg;
    logic    alu_src;
    logic    alu_sc_in;
    logic    read_mem;
    logic    write_mem;
    alu_op_t alu_op;
  } ctrl_t;

  function automatic logic is_halt(input logic [3:0] opcode, input logic fcode);
    return (opcode_t'(opcode) == OP_HALT) && (fcode == OP_HALT_F);
  endfunction

endpackage

// File: rtl/ctrl_sequencer_if.sv
// Host handshake and datapath control bundle of the sequencer.
// Handshake: req is a level held by the host; ack is raised in FIN and stays
// high until the host drops req, which returns the unit to IDLE.
interface ctrl_sequencer_if;
  import definitions::*;

  logic        req;
  logic        ack;
  logic        busy;
  logic        timeout;
  logic [15:0] cycle_count;

  logic [3:0]  opcode;
  logic        fcode;
  logic        DONE;
  logic        START;

  logic        CTRL_branch_rel_nz;
  logic        CTRL_branch_rel_z;
  logic        CTRL_branch_abs;
  logic        CTRL_reg_write_en;
  logic        CTRL_reg_sel;
  logic        CTRL_lut_in;
  logic        CTRL_mem_to_reg;
  logic        CTRL_alu_src;
  logic        CTRL_alu_sc_in;
  logic        CTRL_read_mem;
  logic        CTRL_write_mem;
  logic [2:0]  CTRL_alu_op;

  seq_state_t  state;

  modport master (
    output req, opcode, fcode, DONE,
    input  ack, busy, timeout, cycle_count, START,
    input  CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs,
    input  CTRL_reg_write_en, CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg,
    input  CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem,
    input  CTRL_alu_op, state
  );

  modport slave (
    input  req, opcode, fcode, DONE,
    output ack, busy, timeout, cycle_count, START,
    output CTRL_branch_rel_nz, CTRL_branch_rel_z, CTRL_branch_abs,
    output CTRL_reg_write_en, CTRL_reg_sel, CTRL_lut_in, CTRL_mem_to_reg,
    output CTRL_alu_src, CTRL_alu_sc_in, CTRL_read_mem, CTRL_write_mem,
    output CTRL_alu_op, state
  );

endinterface

// File: rtl/ctrl_sequencer_decode.sv
// Purely combinational instruction decoder: opcode/fcode to datapath strobes.
module ctrl_decode
  import definitions::*;
(
  input  logic [3:0] opcode_i,
  input  logic       fcode_i,
  output ctrl_t      ctrl_o
);

  opcode_t op;
  assign op = opcode_t'(opcode_i);

  always_comb begin
    ctrl_o        = '0;
    ctrl_o.alu_op = ALU_PASS;
    case (op)
      OP_ADD:  begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_ADD; end
      OP_ADDI: begin
        ctrl_o.reg_write_en = 1'b1;
        ctrl_o.alu_op       = ALU_ADD;
        ctrl_o.alu_src      = 1'b1;
      end
      OP_SUB:  begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_SUB; end
      OP_AND:  begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_AND; end
      OP_OR:   begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_OR;  end
      OP_XOR:  begin ctrl_o.reg_write_en = 1'b1; ctrl_o.alu_op = ALU_XOR; end
      OP_SHL: begin
        ctrl_o.reg_write_en = 1'b1;
        ctrl_o.alu_op       = ALU_SHL;
        ctrl_o.alu_sc_in    = fcode_i;
      end
      OP_SHR: begin
        ctrl_o.reg_write_en = 1'b1;
        ctrl_o.alu_op       = ALU_SHR;
        ctrl_o.alu_sc_in    = fcode_i;
      end
      OP_LW: begin
        ctrl_o.read_mem     = 1'b1;
        ctrl_o.mem_to_reg   = 1'b1;
        ctrl_o.reg_write_en = 1'b1;
      end
      OP_SW:   ctrl_o.write_mem     = 1'b1;
      OP_BZ:   ctrl_o.branch_rel_z  = 1'b1;
      OP_BNZ:  ctrl_o.branch_rel_nz = 1'b1;
      OP_JMP:  ctrl_o.branch_abs    = 1'b1;
      OP_JR: begin
        ctrl_o.branch_abs = 1'b1;
        ctrl_o.lut_in     = 1'b1;
      end
      OP_CALL: begin
        ctrl_o.reg_sel      = 1'b1;
        ctrl_o.reg_write_en = 1'b1;
        ctrl_o.branch_abs   = 1'b1;
      end
      // HALT and NOP drive nothing at all, not even the PASS ALU op
      OP_HALT: ctrl_o.alu_op = ALU_ADD;
      default: ctrl_o.alu_op = ALU_PASS;
    endcase
  end

endmodule

// File: rtl/ctrl_sequencer.sv
// Sequencer FSM: host req/ack handshake, datapath START pulse, run-cycle
// watchdog and RUN-gated decode of the instruction stream.
module ctrl_sequencer
  import definitions::*;
#(
  parameter int unsigned INIT_CYCLES = 2,
  parameter logic [15:0] MAX_CYCLES  = 16'hFFFF
) (
  input logic             CLK,
  input logic             reset_n,
  ctrl_sequencer_if.slave bus
);

  localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [15:0] COUNT_LAST = MAX_CYCLES - 16'd1;

  seq_state_t  state_q, state_d;
  logic [3:0]  init_cnt_q, init_cnt_d;
  logic [15:0] cycle_count_q, cycle_count_d;
  logic        timeout_q, timeout_d;

  ctrl_t ctrl_dec;
  ctrl_t ctrl_gated;
  logic  halt;
  logic  count_hit;

  ctrl_decode u_decode (
    .opcode_i (bus.opcode),
    .fcode_i  (bus.fcode),
    .ctrl_o   (ctrl_dec)
  );

  assign halt      = is_halt(bus.opcode, bus.fcode);
  assign count_hit = (cycle_count_q == COUNT_LAST);

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      init_cnt_q    <= '0;
      cycle_count_q <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      cycle_count_q <= cycle_count_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    cycle_count_d = cycle_count_q;
    timeout_d     = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d       = S_INIT;
          init_cnt_d    = '0;
          cycle_count_d = '0;
          timeout_d     = 1'b0;
        end
      end
      S_INIT: begin
        if (!bus.req) begin
          state_d = S_IDLE;
        end else if (init_cnt_q == INIT_LAST) begin
          state_d = S_RUN;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end
      S_RUN: begin
        // The terminating (or aborted) cycle is still counted as a RUN cycle
        cycle_count_d = cycle_count_q + 16'd1;
        if (!bus.req) begin
          state_d = S_IDLE;
        end else if (halt || bus.DONE) begin
          state_d = S_FIN;
        end else if (count_hit) begin
          state_d   = S_FIN;
          timeout_d = 1'b1;
        end
      end
      S_FIN: begin
        if (!bus.req) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.START       = (state_q == S_IDLE) || (state_q == S_INIT);
    bus.busy        = (state_q == S_INIT) || (state_q == S_RUN);
    bus.ack         = (state_q == S_FIN);
    bus.timeout     = timeout_q;
    bus.cycle_count = cycle_count_q;
    bus.state       = state_q;
    ctrl_gated      = (state_q == S_RUN) ? ctrl_dec : '0;
  end

  assign bus.CTRL_branch_rel_nz = ctrl_gated.branch_rel_nz;
  assign bus.CTRL_branch_rel_z  = ctrl_gated.branch_rel_z;
  assign bus.CTRL_branch_abs    = ctrl_gated.branch_abs;
  assign bus.CTRL_reg_write_en  = ctrl_gated.reg_write_en;
  assign bus.CTRL_reg_sel       = ctrl_gated.reg_sel;
  assign bus.CTRL_lut_in        = ctrl_gated.lut_in;
  assign bus.CTRL_mem_to_reg    = ctrl_gated.mem_to_reg;
  assign bus.CTRL_alu_src       = ctrl_gated.alu_src;
  assign bus.CTRL_alu_sc_in     = ctrl_gated.alu_sc_in;
  assign bus.CTRL_read_mem      = ctrl_gated.read_mem;
  assign bus.CTRL_write_mem     = ctrl_gated.write_mem;
  assign bus.CTRL_alu_op        = ctrl_gated.alu_op;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Bench for ctrl_sequencer: runs are planned as whole transactions, expanded
// into a per-cycle stimulus queue and an expected-output queue, then replayed.
module tb_ctrl_sequencer;
  import definitions::*;

  localparam int INIT_C = 2;
  localparam int MAX_C  = 5;

  logic CLK;
  logic reset_n;

  ctrl_sequencer_if bus();

  ctrl_sequencer #(
    .INIT_CYCLES (INIT_C),
    .MAX_CYCLES  (16'(MAX_C))
  ) dut (
    .CLK     (CLK),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;

  logic [6:0]  stim_q[$];   // {req, opcode, fcode, DONE}
  logic [33:0] exp_q[$];    // {START, busy, ack, timeout, cycle_count, ctrl}
  logic [3:0]  p_op[$];
  logic        p_fc[$];
  logic        p_dn[$];
  int          m_cnt = 0;
  logic        m_to  = 1'b0;

  function automatic logic [33:0] pk(input logic st, input logic bz, input logic ak,
                                     input logic to, input logic [15:0] c,
                                     input logic [13:0] ctl);
    return {st, bz, ak, to, c, ctl};
  endfunction

  // Strobe table written from the instruction list:
  // {bnz, bz, babs, rwe, rsel, lut, m2r, asrc, sc, rd, wr, alu[2:0]}
  function automatic logic [13:0] dec(input logic [3:0] op, input logic fc);
    logic bnz, bz, babs, rwe, rsel, lut, m2r, asrc, sc, rd, wr;
    logic [2:0] alu;
    {bnz, bz, babs, rwe, rsel, lut, m2r, asrc, sc, rd, wr} = '0;
    alu = 3'd7;
    if (op < 4'd8) begin
      rwe  = 1'b1;
      asrc = (op == 4'd1);
      sc   = (op >= 4'd6) && fc;
      alu  = (op < 4'd2) ? 3'd0 : 3'(op - 4'd1);
    end else begin
      case (op)
        4'd8:  begin rd = 1'b1; m2r = 1'b1; rwe = 1'b1; end
        4'd9:  wr = 1'b1;
        4'd10: bz = 1'b1;
        4'd11: bnz = 1'b1;
        4'd12: babs = 1'b1;
        4'd13: begin babs = 1'b1; lut = 1'b1; end
        4'd14: begin rsel = 1'b1; rwe = 1'b1; babs = 1'b1; end
        default: alu = 3'd0;
      endcase
    end
    return {bnz, bz, babs, rwe, rsel, lut, m2r, asrc, sc, rd, wr, alu};
  endfunction

  function automatic logic [33:0] obs_vec();
    return pk(bus.START, bus.busy, bus.ack, bus.timeout, bus.cycle_count,
              {bus.CTRL_branch_rel_nz, bus.CTRL_branch_rel_z, bus.CTRL_branch_abs,
               bus.CTRL_reg_write_en, bus.CTRL_reg_sel, bus.CTRL_lut_in,
               bus.CTRL_mem_to_reg, bus.CTRL_alu_src, bus.CTRL_alu_sc_in,
               bus.CTRL_read_mem, bus.CTRL_write_mem, bus.CTRL_alu_op});
  endfunction

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%09h expected=%09h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic push(input logic rq, input logic [3:0] op, input logic fc,
                      input logic dn, input logic [33:0] e);
    stim_q.push_back({rq, op, fc, dn});
    exp_q.push_back(e);
  endtask

  task automatic push_rand(input logic rq, input logic [33:0] e);
    push(rq, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
         1'($urandom_range(0, 1)), e);
  endtask

  task automatic add_op(input logic [3:0] op, input logic fc, input logic dn);
    p_op.push_back(op);
    p_fc.push_back(fc);
    p_dn.push_back(dn);
  endtask

  // Expand one host transaction (program in p_*) into cycles of stimulus and
  // expectation. Past the end of the program the datapath shows NOP.
  task automatic plan_run(input int gap, input int abort_at, input int fin_len);
    int k;
    logic [3:0] op;
    logic fc, dn, halt, hit, to, aborted, ended;
    repeat (gap) push_rand(1'b0, pk(1'b1, 1'b0, 1'b0, m_to, 16'(m_cnt), 14'd0));
    push_rand(1'b1, pk(1'b1, 1'b0, 1'b0, m_to, 16'(m_cnt), 14'd0));
    repeat (INIT_C) push_rand(1'b1, pk(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 14'd0));
    k = 0; to = 1'b0; aborted = 1'b0; ended = 1'b0;
    while (!ended) begin
      k++;
      if (k <= p_op.size()) begin
        op = p_op[k-1]; fc = p_fc[k-1]; dn = p_dn[k-1];
      end else begin
        op = 4'd15; fc = 1'b1; dn = 1'b0;
      end
      halt = (op == 4'd15) && !fc;
      hit  = (k == MAX_C);
      push(abort_at != k, op, fc, dn, pk(1'b0, 1'b1, 1'b0, 1'b0, 16'(k - 1), dec(op, fc)));
      if (abort_at == k) begin
        aborted = 1'b1; ended = 1'b1;
      end else if (halt || dn || hit) begin
        to = hit && !halt && !dn; ended = 1'b1;
      end
    end
    if (aborted) begin
      m_cnt = k; m_to = 1'b0;
    end else begin
      for (int f = 0; f <= fin_len; f++)
        push_rand(f < fin_len, pk(1'b0, 1'b0, 1'b1, to, 16'(k), 14'd0));
      m_cnt = k; m_to = to;
    end
    p_op.delete(); p_fc.delete(); p_dn.delete();
  endtask

  task automatic step();
    logic [6:0] s;
    @(posedge CLK);
    #1;
    s = stim_q.pop_front();
    {bus.req, bus.opcode, bus.fcode, bus.DONE} = s;
    @(negedge CLK);
    ncyc++;
    chk($sformatf("cyc%0d", ncyc), obs_vec(), exp_q.pop_front());
  endtask

  task automatic drain();
    while (stim_q.size() > 0) step();
  endtask

  initial begin
    int n, ab;
    reset_n = 1'b0;
    bus.req = 1'b1; bus.opcode = 4'd0; bus.fcode = 1'b0; bus.DONE = 1'b1;
    #12;
    chk("reset_out", obs_vec(), pk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 14'd0));
    chk("reset_state", 34'(bus.state), 34'(S_IDLE));
    bus.req = 1'b0; bus.DONE = 1'b0;
    @(posedge CLK); #3 reset_n = 1'b1;

    // basic run: ADD, ADDI, HALT
    add_op(4'd0, 1'b0, 1'b0); add_op(4'd1, 1'b1, 1'b0); add_op(4'd15, OP_HALT_F, 1'b0);
    plan_run(1, 0, 2); drain();

    // watchdog: NOP until the budget runs out
    plan_run(1, 0, 1); drain();

    // coincident exits: HALT, then DONE, on the last budgeted cycle
    repeat (4) add_op(4'd15, OP_NOP_F, 1'b0);
    add_op(4'd15, OP_HALT_F, 1'b0);
    plan_run(0, 0, 1); drain();
    repeat (4) add_op(4'd15, OP_NOP_F, 1'b0);
    add_op(4'd2, 1'b0, 1'b1);
    plan_run(2, 0, 2); drain();

    // abort in RUN cycle 2
    add_op(4'd0, 1'b0, 1'b0); add_op(4'd2, 1'b0, 1'b0); add_op(4'd3, 1'b0, 1'b0);
    plan_run(1, 2, 1); drain();

    // decode sweep, both fcode values, five opcodes per run
    for (int fv = 0; fv < 2; fv++) begin
      for (int base = 0; base < 15; base += 5) begin
        for (int o = base; o < base + 5; o++) add_op(4'(o), 1'(fv), 1'b0);
        plan_run(1, 0, 1); drain();
      end
    end
    add_op(4'd15, OP_NOP_F, 1'b0); add_op(4'd15, OP_HALT_F, 1'b0);
    plan_run(0, 0, 1); drain();

    // DONE ends the run on an LW
    add_op(4'd0, 1'b0, 1'b0); add_op(4'd9, 1'b0, 1'b0); add_op(4'd8, 1'b1, 1'b1);
    plan_run(1, 0, 2); drain();

    // asynchronous reset in the middle of RUN, away from the clock edge
    add_op(4'd0, 1'b0, 1'b0); add_op(4'd2, 1'b0, 1'b0);
    add_op(4'd14, 1'b0, 1'b0); add_op(4'd8, 1'b0, 1'b0);
    plan_run(0, 0, 1);
    repeat (1 + INIT_C + 3) step();
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_out", obs_vec(), pk(1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 14'd0));
    chk("async_rst_state", 34'(bus.state), 34'(S_IDLE));
    stim_q.delete(); exp_q.delete();
    m_cnt = 0; m_to = 1'b0;
    bus.req = 1'b0;
    @(posedge CLK); #3 reset_n = 1'b1;

    // random transactions
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++)
        add_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 7) == 0));
      ab = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0;
      plan_run($urandom_range(0, 2), ab, $urandom_range(1, 3));
      drain();
    end

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
